// File: rtl/codifica_hamming_tx.sv
// Hamming(15,11) transmit stage: encodes an 11-bit word, optionally flips one
// codeword bit, and sends the codeword LSB-first between a start and stop bit.
//
// state  | meaning
// -------+------------------------------------------------------------
// OCIOSO | line idle at 1, ready for a new word
// INICIO | start bit (0) held for CICLOS_POR_BIT cycles
// DADOS  | codeword bit [idx] held for CICLOS_POR_BIT cycles, idx 0..14
// FIM    | stop bit (1) held for CICLOS_POR_BIT cycles
module codifica_hamming_tx #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] entrada,
    input  logic [3:0]  erro_pos,
    input  logic        entrada_valida,
    output logic        pronto,
    output logic        serial_saida,
    output logic        ocupado,
    output logic [14:0] palavra
);

    localparam int CW = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_POR_BIT - 1);

    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, FIM} estado_t;

    estado_t       estado, estado_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0]    idx, idx_next;
    logic [14:0]   palavra_next;
    logic [14:0]   cod_limpo;
    logic [14:0]   mascara;
    logic          serial_next, pronto_next, ocupado_next;
    logic          transfer;
    logic          fim_bit;

    assign transfer = entrada_valida & pronto;
    assign fim_bit  = (cnt == CNT_MAX);

    // Encoder: parity always computed over the clean data bits.
    always_comb begin
        cod_limpo        = '0;
        cod_limpo[2]     = entrada[0];
        cod_limpo[6:4]   = entrada[3:1];
        cod_limpo[11:8]  = entrada[7:4];
        cod_limpo[14:12] = entrada[10:8];
        cod_limpo[0] = cod_limpo[2] ^ cod_limpo[4] ^ cod_limpo[6] ^ cod_limpo[8]
                     ^ cod_limpo[10] ^ cod_limpo[12] ^ cod_limpo[14];
        cod_limpo[1] = cod_limpo[2] ^ cod_limpo[5] ^ cod_limpo[6] ^ cod_limpo[9]
                     ^ cod_limpo[10] ^ cod_limpo[13] ^ cod_limpo[14];
        cod_limpo[3] = cod_limpo[4] ^ cod_limpo[5] ^ cod_limpo[6] ^ cod_limpo[11]
                     ^ cod_limpo[12] ^ cod_limpo[13] ^ cod_limpo[14];
        cod_limpo[7] = ^cod_limpo[14:8];
        mascara = '0;
        if (erro_pos != 4'd0)
            mascara = 15'd1 << (erro_pos - 4'd1);
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        estado_next  = estado;
        cnt_next     = cnt;
        idx_next     = idx;
        palavra_next = palavra;
        case (estado)
            OCIOSO: begin
                if (transfer) begin
                    palavra_next = cod_limpo ^ mascara;
                    estado_next  = INICIO;
                    cnt_next     = '0;
                    idx_next     = 4'd0;
                end
            end
            INICIO: begin
                if (fim_bit) begin
                    cnt_next    = '0;
                    idx_next    = 4'd0;
                    estado_next = DADOS;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DADOS: begin
                if (fim_bit) begin
                    cnt_next = '0;
                    if (idx == 4'd14) begin
                        idx_next    = 4'd0;
                        estado_next = FIM;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            FIM: begin
                if (fim_bit) begin
                    cnt_next    = '0;
                    estado_next = OCIOSO;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                cnt_next    = '0;
                idx_next    = 4'd0;
                estado_next = OCIOSO;
            end
        endcase

        serial_next  = 1'b1;
        pronto_next  = 1'b0;
        ocupado_next = 1'b1;
        case (estado_next)
            OCIOSO: begin
                pronto_next  = 1'b1;
                ocupado_next = 1'b0;
            end
            INICIO:  serial_next = 1'b0;
            DADOS:   serial_next = palavra_next[idx_next];
            default: serial_next = 1'b1;
        endcase
    end

    // State, counters and outputs all come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= OCIOSO;
            cnt          <= '0;
            idx          <= 4'd0;
            palavra      <= '0;
            serial_saida <= 1'b1;
            pronto       <= 1'b1;
            ocupado      <= 1'b0;
        end else begin
            estado       <= estado_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            palavra      <= palavra_next;
            serial_saida <= serial_next;
            pronto       <= pronto_next;
            ocupado      <= ocupado_next;
        end
    end

endmodule

// File: tb/tb_codifica_hamming_tx.sv
// Directed bench for codifica_hamming_tx with N = 4 cycles per bit.
module tb_codifica_hamming_tx;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] entrada = '0;
    logic [3:0]  erro_pos = '0;
    logic        entrada_valida = 1'b0;
    logic        pronto;
    logic        serial_saida;
    logic        ocupado;
    logic [14:0] palavra;

    int checks = 0;
    int errors = 0;

    codifica_hamming_tx #(.CICLOS_POR_BIT(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .entrada        (entrada),
        .erro_pos       (erro_pos),
        .entrada_valida (entrada_valida),
        .pronto         (pronto),
        .serial_saida   (serial_saida),
        .ocupado        (ocupado),
        .palavra        (palavra)
    );

    always #5 clk = ~clk;

    // Independent single-error corrector: syndrome is XOR of 1-based positions of set bits.
    function automatic logic [10:0] decode(input logic [14:0] c_in);
        logic [14:0] c;
        logic [3:0]  s;
        c = c_in;
        s = 4'd0;
        for (int j = 0; j < 15; j++)
            if (c[j]) s = s ^ 4'(j + 1);
        if (s != 4'd0) c[s - 4'd1] = ~c[s - 4'd1];
        return {c[14:12], c[11:8], c[6:4], c[2]};
    endfunction

    task automatic wait_idle(input string nome);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (pronto === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: pronto never returned to 1 (got %b, want 1)", nome, pronto);
        end
    endtask

    // Presents one word, returns just after the transfer edge and checks the T-outputs.
    task automatic send(input logic [10:0] d, input logic [3:0] e, input logic [14:0] exp_pal,
                        input string nome);
        @(negedge clk);
        entrada = d;
        erro_pos = e;
        entrada_valida = 1'b1;
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        checks++;
        if (palavra !== exp_pal) begin
            errors++;
            $display("FAIL %s palavra: got %h, want %h", nome, palavra, exp_pal);
        end
        checks++;
        if ({pronto, ocupado, serial_saida} !== 3'b010) begin
            errors++;
            $display("FAIL %s start flags pronto/ocupado/serial: got %b, want 010", nome,
                     {pronto, ocupado, serial_saida});
        end
    endtask

    // Walks the 68 cycles after a transfer, checking each bit mid-period.
    // With busy=1 it holds a competing word on the inputs the whole time.
    task automatic check_frame(input logic [14:0] cw, input bit busy, input string nome);
        logic exp_bit;
        if (busy) begin
            entrada = 11'h555;
            erro_pos = 4'd0;
            entrada_valida = 1'b1;
        end
        for (int c = 0; c < 17 * N; c++) begin
            @(negedge clk);
            if (c % N == N / 2) begin
                if (c / N == 0) exp_bit = 1'b0;
                else if (c / N == 16) exp_bit = 1'b1;
                else exp_bit = cw[c / N - 1];
                checks++;
                if (serial_saida !== exp_bit) begin
                    errors++;
                    $display("FAIL %s bit slot %0d: got %b, want %b", nome, c / N, serial_saida, exp_bit);
                end
                if (busy) begin
                    checks++;
                    if (palavra !== cw) begin
                        errors++;
                        $display("FAIL %s palavra while busy: got %h, want %h", nome, palavra, cw);
                    end
                end
            end
            if (c == 17 * N - 1) begin
                checks++;
                if (pronto !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pronto early at T+%0d: got %b, want 0", nome, c, pronto);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({pronto, ocupado, serial_saida} !== 3'b101) begin
            errors++;
            $display("FAIL %s idle at T+68 pronto/ocupado/serial: got %b, want 101", nome,
                     {pronto, ocupado, serial_saida});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({serial_saida, pronto, ocupado} !== 3'b110) begin
            errors++;
            $display("FAIL reset flags serial/pronto/ocupado: got %b, want 110",
                     {serial_saida, pronto, ocupado});
        end
        checks++;
        if (palavra !== 15'h0000) begin
            errors++;
            $display("FAIL reset palavra: got %h, want 0000", palavra);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({serial_saida, pronto, ocupado, palavra} !== {3'b110, 15'h0000}) begin
                errors++;
                $display("FAIL idle hold cycle %0d: got %b/%h, want 110/0000", i,
                         {serial_saida, pronto, ocupado}, palavra);
            end
        end
    endtask

    task automatic test_encoding;
        send(11'h001, 4'd0, 15'h0007, "enc_001"); wait_idle("enc_001");
        send(11'h400, 4'd0, 15'h408B, "enc_400"); wait_idle("enc_400");
        send(11'h7FF, 4'd0, 15'h7FFF, "enc_7FF"); wait_idle("enc_7FF");
        send(11'h000, 4'd0, 15'h0000, "enc_000"); wait_idle("enc_000");
        send(11'h555, 4'd0, 15'h552D, "enc_555"); wait_idle("enc_555");
    endtask

    task automatic test_serial_frame;
        send(11'h400, 4'd0, 15'h408B, "frame_400");
        check_frame(15'h408B, 1'b0, "frame_400");
    endtask

    task automatic test_error_injection;
        logic [14:0] exp_cw;
        send(11'h001, 4'd3, 15'h0003, "inj_pos3");
        wait_idle("inj_pos3");
        for (int k = 1; k <= 15; k++) begin
            exp_cw = 15'h0007 ^ (15'd1 << (k - 1));
            send(11'h001, 4'(k), exp_cw, $sformatf("inj_pos%0d", k));
            checks++;
            if (decode(palavra) !== 11'h001) begin
                errors++;
                $display("FAIL inj_pos%0d recovered: got %h, want 001", k, decode(palavra));
            end
            wait_idle($sformatf("inj_pos%0d", k));
        end
    endtask

    task automatic test_busy_rejection;
        bit ok;
        send(11'h001, 4'd0, 15'h0007, "busy");
        check_frame(15'h0007, 1'b1, "busy");
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ocupado === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        entrada_valida = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy held word not accepted: ocupado got %b, want 1", ocupado);
        end
        checks++;
        if (palavra !== 15'h552D) begin
            errors++;
            $display("FAIL busy held word palavra: got %h, want 552D", palavra);
        end
        wait_idle("busy_tail");
    endtask

    task automatic test_reset_mid_frame;
        send(11'h400, 4'd0, 15'h408B, "midrst");
        repeat ((1 + 7) * N + 1) @(negedge clk);
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL midrst before reset ocupado: got %b, want 1", ocupado);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({serial_saida, pronto, ocupado} !== 3'b110) begin
            errors++;
            $display("FAIL midrst async flags serial/pronto/ocupado: got %b, want 110",
                     {serial_saida, pronto, ocupado});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(11'h001, 4'd0, 15'h0007, "after_rst");
        check_frame(15'h0007, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_serial_frame();
        test_error_injection();
        test_busy_rejection();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/codifica_hamming_tx.md
# codifica_hamming_tx

Upstream transmit stage of the Hamming(15,11) link. It accepts 11-bit data words over a valid/ready handshake and encodes each one into a 15-bit codeword. It uses the same bit layout that the downstream corrector expects. It then serializes the codeword LSB-first with start and stop bits on a single line. An optional error-injection input flips one codeword bit per frame, so the receive/correct path can be exercised end to end.

## Interface
Parameters:
- CICLOS_POR_BIT, default 4: clock cycles each serial bit is held. Legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- entrada  input  11  data word to encode.
- erro_pos  input  4  error injection. 0 means no error; k in 1..15 flips codeword bit k-1. Sampled with entrada.
- entrada_valida  input  1  entrada/erro_pos are valid.
- pronto  output  1  block can accept a word (IDLE only).
- serial_saida  output  1  serial line; idle level 1.
- ocupado  output  1  a frame is in progress.
- palavra  output  15  codeword of the last accepted word, after injection. Held until the next acceptance.

## Operation
Encoding, with c the codeword and d = entrada:
- Data bits: c[2]=d[0]; c[6:4]=d[3:1]; c[11:8]=d[7:4]; c[14:12]=d[10:8].
- c[0] = XOR of c[2,4,6,8,10,12,14].
- c[1] = XOR of c[2,5,6,9,10,13,14].
- c[3] = XOR of c[4,5,6,11,12,13,14].
- c[7] = XOR of c[8..14].
- If erro_pos≠0, the stored codeword is c ^ (1 << (erro_pos-1)). Parity is always computed on clean data before injection.

Handshake:
- A transfer occurs on a rising edge where entrada_valida=1 and pronto=1.
- entrada_valida while pronto=0 is ignored; there is no buffering, and the word is not queued.

State machine (OCIOSO, INICIO, DADOS, FIM):
- OCIOSO: serial_saida=1, pronto=1, ocupado=0. On transfer: latch codeword into the shift register and palavra, then go to INICIO.
- INICIO: serial_saida=0 for CICLOS_POR_BIT cycles, then go to DADOS with bit index 0.
- DADOS: serial_saida=c[index] for CICLOS_POR_BIT cycles per bit, index 0..14 (LSB first). After index 14 completes, go to FIM.
- FIM: serial_saida=1 for CICLOS_POR_BIT cycles, then go to OCIOSO.

Counters:
- Cycle counter: 0..CICLOS_POR_BIT-1, wraps to 0 at every bit boundary.
- Bit index: 4 bits, 0..14; never reaches 15.

Reset:
- rst_n low forces OCIOSO at any time, including mid-frame. The partial frame is abandoned.
- Reset values: serial_saida=1, pronto=1, ocupado=0, palavra=0, counters 0.

## Timing
- Transfer at edge T:
  - pronto=0 and ocupado=1 from T.
  - palavra valid from T.
  - serial_saida=0 (start bit) from T.
- Bit c[i] is driven during cycles [T+(1+i)·N, T+(2+i)·N), where N = CICLOS_POR_BIT.
- The stop bit occupies [T+16N, T+17N).
- pronto=1 at T+17N, so the next transfer can occur at edge T+17N. Back-to-back frames are 17N cycles apart with no extra idle bit.
- Outputs are registered; no combinational path from inputs to serial_saida or pronto.
- N=1 is legal: one cycle per bit, 17-cycle frames.

## Test plan
- Reset then idle: hold rst_n=0, release → serial_saida=1, pronto=1, ocupado=0, palavra=15'h0000. Hold for 20 cycles with no valid; outputs must not change.
- Encoding with N=4 and erro_pos=0:
  - entrada=11'h001 → palavra=15'h0007.
  - entrada=11'h400 → palavra=15'h408B.
  - entrada=11'h7FF → palavra=15'h7FFF.
  - entrada=11'h000 → palavra=15'h0000.
- Serial frame, N=4, entrada=11'h400: sample serial_saida mid-bit. Required sequence: start 0, then 1,1,0,1,0,0,0,1,0,0,0,0,0,0,1, then stop 1. pronto returns to 1 exactly 68 cycles after the transfer edge.
- Error injection: entrada=11'h001, erro_pos=3 → palavra=15'h0003. A downstream corrector must recover 11'h001. Repeat for erro_pos=1..15; each must recover.
- Busy rejection: assert entrada_valida=1 with entrada=11'h555 during a frame → palavra and the frame are unchanged. If valid is still held at T+68, it is accepted then.
- Reset mid-frame: pull rst_n low during DADOS bit 7 → serial_saida=1 and pronto=1 immediately (asynchronous). A new transfer after release yields a complete, correct frame.
